// File: rtl/mdu.sv
// rtl/mdu.sv - iterative MIPS multiply/divide unit with HI/LO registers
//
// Runs MULT/MULTU/DIV/DIVU one step per clock under a start/busy/done
// handshake, and takes MTHI/MTLO writes while idle.
// Optional feature macro: MDU_DIV_EN (defined = DIV/DIVU implemented; undefined =
// divide ops complete in one step and leave HI/LO and div_by_zero untouched).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start_i, op_i       launch (IDLE only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i            multiplicand/dividend, multiplier/divisor
//   hilo_we_i, hilo_sel_i, hilo_wdata_i   MTLO (sel 0) / MTHI (sel 1) write
//   busy_o              operation in flight
//   done_o              one-cycle pulse, HI/LO hold the new result
//   hi_o, lo_o          HI/LO registers
//   div_by_zero_o       last divide had a zero divisor
module mdu #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              hilo_we_i,
   input  logic              hilo_sel_i,
   input  logic [DATA_W-1:0] hilo_wdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              div_by_zero_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  div_q, div_d;     // running op is a divide
   logic                  neg_q, neg_d;     // operand signs differ (signed ops only)
   logic [DATA_W-1:0]     mcand_q, mcand_d; // |a| for multiply, |b| for divide
   logic [2*DATA_W-1:0]   acc_q, acc_d;     // product, or dividend/quotient in low half
   logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                  done_q, done_d;
   logic                  dbz_q, dbz_d;

   logic                  a_neg, b_neg;
   logic [DATA_W-1:0]     a_abs, b_abs;
   logic [DATA_W:0]       mult_sum;
   logic [2*DATA_W-1:0]   prod_fix;

   assign a_neg    = ~op_i[0] & a_i[DATA_W-1];
   assign b_neg    = ~op_i[0] & b_i[DATA_W-1];
   assign a_abs    = a_neg ? -a_i : a_i;
   assign b_abs    = b_neg ? -b_i : b_i;
   // Add the multiplicand into the upper half when the current multiplier bit is set;
   // the carry is kept so the following right shift does not lose it.
   assign mult_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
   assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
   logic                  sa_q, sa_d;       // dividend sign, gives remainder sign
   logic                  dz_q, dz_d;       // zero divisor pending for FIX
   logic [DATA_W-1:0]     rem_q, rem_d;
   logic [DATA_W:0]       rem_shift, rem_diff;
   logic [DATA_W-1:0]     quo_fix, rem_fix;

   // Restoring step on a DATA_W+1 bit partial remainder: no borrow means the trial
   // subtraction is kept and the quotient bit is 1.
   assign rem_shift = {rem_q, acc_q[DATA_W-1]};
   assign rem_diff  = rem_shift - {1'b0, mcand_q};
   assign quo_fix   = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem_fix   = sa_q ? -rem_q : rem_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef MDU_DIV_EN
         sa_q    <= 1'b0;
         dz_q    <= 1'b0;
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
`ifdef MDU_DIV_EN
         sa_q    <= sa_d;
         dz_q    <= dz_d;
         rem_q   <= rem_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
`ifdef MDU_DIV_EN
      sa_d    = sa_q;
      dz_d    = dz_q;
      rem_d   = rem_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               div_d   = op_i[1];
               neg_d   = a_neg ^ b_neg;
               cnt_d   = CNT_LOAD;
               dbz_d   = 1'b0;
               if (!op_i[1]) begin
                  mcand_d = a_abs;
                  acc_d   = {{DATA_W{1'b0}}, b_abs};
                  state_d = S_ITER;
               end else begin
`ifdef MDU_DIV_EN
                  sa_d    = a_neg;
                  dz_d    = (b_i == '0);
                  rem_d   = '0;
                  mcand_d = b_abs;
                  if (b_i == '0) begin
                     acc_d   = {{DATA_W{1'b0}}, a_i};  // raw dividend goes to HI
                     state_d = S_FIX;
                  end else begin
                     acc_d   = {{DATA_W{1'b0}}, a_abs};
                     state_d = S_ITER;
                  end
`else
                  state_d = S_FIX;
`endif
               end
            end else if (hilo_we_i) begin
               if (hilo_sel_i) hi_d = hilo_wdata_i;
               else            lo_d = hilo_wdata_i;
            end
         end
         S_ITER: begin
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
`ifdef MDU_DIV_EN
            if (div_q) begin
               rem_d = rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
               acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], ~rem_diff[DATA_W]};
            end else begin
               acc_d = {mult_sum, acc_q[DATA_W-1:1]};
            end
`else
            acc_d = {mult_sum, acc_q[DATA_W-1:1]};
`endif
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!div_q) begin
               hi_d = prod_fix[2*DATA_W-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end
`ifdef MDU_DIV_EN
            else if (dz_q) begin
               hi_d  = acc_q[DATA_W-1:0];
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized scoreboard bench for mdu against an arithmetic reference model
module tb_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_i = 1'b0;
   logic [1:0]    op_i = '0;
   logic [W-1:0]  a_i = '0, b_i = '0;
   logic          hilo_we_i = 1'b0, hilo_sel_i = 1'b0;
   logic [W-1:0]  hilo_wdata_i = '0;
   logic          busy_o, done_o, div_by_zero_o;
   logic [W-1:0]  hi_o, lo_o;

   mdu #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .hilo_we_i(hilo_we_i), .hilo_sel_i(hilo_sel_i), .hilo_wdata_i(hilo_wdata_i),
      .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
      .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t         q[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the arithmetic definition of each op.
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output exp_t e);
      longint          sp, sq, sr;
      longint unsigned up, uq, ur;
      e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.lat = W + 1; e.acc_cyc = 0;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            e.hi = sp[63:32]; e.lo = sp[31:0];
         end
         2'b01: begin
            up = {32'b0, a} * {32'b0, b};
            e.hi = up[63:32]; e.lo = up[31:0];
         end
         default: begin
`ifdef MDU_DIV_EN
            if (b == '0) begin
               e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
            end else if (op == 2'b10) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               e.hi = sr[31:0]; e.lo = sq[31:0];
            end else begin
               uq = {32'b0, a} / {32'b0, b};
               ur = {32'b0, a} % {32'b0, b};
               e.hi = ur[31:0]; e.lo = uq[31:0];
            end
`else
            e.lat = 1;
`endif
         end
      endcase
      m_hi = e.hi; m_lo = e.lo;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done_o) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("hi", hi_o, e.hi);
            chk("lo", lo_o, e.lo);
            chk("div_by_zero", div_by_zero_o, e.dbz);
            chk("latency", cyc - e.acc_cyc, e.lat);
            chk("busy_at_done", busy_o, 0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic we);
      exp_t e;
      int   n = 0;
      while (busy_o && n < 200) begin @(negedge clk); n++; end
      if (busy_o) chk("busy_timeout", 1, 0);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      hilo_we_i = we; hilo_sel_i = $urandom_range(0, 1); hilo_wdata_i = $urandom;
      model(op, a, b, e);
      @(posedge clk); #1;
      e.acc_cyc = cyc;
      q.push_back(e);
      start_i = 1'b0; hilo_we_i = 1'b0;
      a_i = $urandom; b_i = $urandom;  // operands are free to change after accept
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || busy_o) && n < 200) begin @(negedge clk); n++; end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] specials [6];
      specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_busy", busy_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_hi", hi_o, 0);
      chk("reset_lo", lo_o, 0);
      chk("reset_dbz", div_by_zero_o, 0);
      reset = 1'b0;
      @(negedge clk);

      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      issue(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      issue(2'b11, 32'h00001234, 32'h0, 1'b0);
      issue(2'b01, 32'h00000003, 32'h00000007, 1'b0);
      drain();

      // MTLO / MTHI in IDLE
      hilo_we_i = 1'b1; hilo_sel_i = 1'b0; hilo_wdata_i = 32'hAAAA5555;
      @(posedge clk); #1;
      chk("mtlo", lo_o, 32'hAAAA5555);
      m_lo = 32'hAAAA5555;
      hilo_sel_i = 1'b1; hilo_wdata_i = 32'h0F0F1234;
      @(posedge clk); #1;
      chk("mthi", hi_o, 32'h0F0F1234);
      chk("mthi_lo_kept", lo_o, 32'hAAAA5555);
      m_hi = 32'h0F0F1234;
      hilo_we_i = 1'b0;
      @(negedge clk);

      // start and hilo_we while busy are ignored
      issue(2'b00, 32'h12345678, 32'hFEDCBA98, 1'b0);
      repeat (3) @(negedge clk);
      start_i = 1'b1; op_i = 2'b11; b_i = '0;
      hilo_we_i = 1'b1; hilo_sel_i = 1'b0; hilo_wdata_i = 32'hDEADBEEF;
      @(negedge clk);
      start_i = 1'b0; hilo_we_i = 1'b0;
      drain();

      // start beats a simultaneous hilo write in IDLE
      issue(2'b01, 32'h0000FFFF, 32'h00010001, 1'b1);
      drain();

      for (int i = 0; i < 30; i++) begin
         logic [1:0]   op;
         logic [W-1:0] a, b;
         op = 2'($urandom_range(0, 3));
         a = pick();
         b = ($urandom_range(0, 5) == 0) ? '0 : pick();
         issue(op, a, b, 1'b0);
      end
      drain();

      // Reset 10 cycles into a MULTU aborts with no done
      issue(2'b01, 32'hCAFEF00D, 32'h12345678, 1'b0);
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_hi", hi_o, 0);
      chk("abort_lo", lo_o, 0);
      q.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_abort_hi", hi_o, 0);
      chk("post_abort_lo", lo_o, 0);
      chk("post_abort_busy", busy_o, 0);

      issue(2'b00, 32'h00000010, 32'hFFFFFFFF, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit with architectural HI/LO registers, the next-generation arithmetic block beside the single-cycle ALU. It executes MIPS MULT/MULTU/DIV/DIVU as a multi-cycle operation: one partial-product or restoring-divide step per clock, under a start/busy/done handshake. It also services MTHI/MTLO writes. The datapath stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `DATA_W`, default 32: operand width. HI and LO are each `DATA_W` bits. Must be even and ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `a`  in  DATA_W  multiplicand / dividend (rs)
- `b`  in  DATA_W  multiplier / divisor (rt)
- `hilo_we`  in  1  MTHI/MTLO write strobe
- `hilo_sel`  in  1  0 = write LO, 1 = write HI
- `hilo_wdata`  in  DATA_W  MTHI/MTLO data
- `busy`  out  1  operation in flight; datapath must stall MDU instructions and MFHI/MFLO
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in that cycle
- `hi`  out  DATA_W  HI register (product high half / remainder)
- `lo`  out  DATA_W  LO register (product low half / quotient)
- `div_by_zero`  out  1  set with `done` of a DIV/DIVU whose `b` was 0; cleared on the next accepted start

## Operation
- FSM states: IDLE, ITER, FIX.
- **IDLE:**
  - `start` = 1 latches `op`, `|a|`, `|b|` and the sign flags. Absolute values apply to signed ops only; unsigned ops use raw values.
  - The accepting edge also loads the step counter with `DATA_W` and moves to ITER.
- **ITER, multiply:** shift-add one multiplier bit per cycle into a `2*DATA_W` accumulator.
- **ITER, divide:** restoring divide, one quotient bit per cycle; remainder is `DATA_W+1` bits internally.
- **ITER exit:** when the counter reaches 0 after `DATA_W` steps, move to FIX.
- **FIX:**
  - MULT: negate the `2*DATA_W` product if sign(a) ≠ sign(b).
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - The resulting values are written to HI/LO; go to IDLE.
- **Divide by zero** (DIV/DIVU with `b` = 0): skip ITER. The accept edge goes straight to FIX, which writes `lo` = all ones and `hi` = `a` and sets `div_by_zero`.
- **Signed overflow** (DIV of most-negative value by −1): `lo` = most-negative value, `hi` = 0; no flag.
- **MTHI/MTLO:** in IDLE with `hilo_we` = 1, the selected register takes `hilo_wdata` at the edge.
- **Simultaneous events:**
  - `start` and `hilo_we` both high in IDLE: `start` wins and the write is dropped.
  - `start` or `hilo_we` while busy: ignored, with no effect on the running operation.
- Operands `a`/`b` may change after the accept edge; they are not sampled again.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `div_by_zero` 0, counter 0.
- Reset asserted mid-operation aborts immediately. HI/LO take the reset value and no `done` is produced.
- Timing is relative to accept edge k.
- **Normal operation:**
  - `busy` = 1 from after edge k until edge k+`DATA_W`+1.
  - The FIX edge k+`DATA_W`+1 writes HI/LO, drops `busy` and raises `done` for exactly one cycle.
  - Total latency is `DATA_W`+1 cycles: 33 cycles for `DATA_W` = 32.
- **Divide by zero:** FIX at edge k+1, so `done` is high in the cycle after k+1 and `busy` is high for one cycle.
- **Back-to-back:** a new `start` may be accepted in the same cycle `done` is high, since the state is already IDLE.
- HI/LO are stable except at the FIX edge, an MTHI/MTLO edge, or reset.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `MDU_DIV_EN` undefined:
  - Divider logic is compiled out; only MULT/MULTU iterate.
  - A `start` with `op` = 10/11 is accepted and goes directly to FIX, so `done` pulses after edge k+1.
  - HI/LO are unchanged and `div_by_zero` stays 0.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` after edge k+33, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high for 33 cycles.
- MULT a=−3 (0xFFFFFFFD), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV a=−7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU a=0x1234, b=0 -> `done` after edge k+1, `lo`=0xFFFFFFFF, `hi`=0x00001234, `div_by_zero`=1. Next MULTU start clears the flag.
- **Ignored inputs while busy:**
  - MTLO 0xAAAA5555 in IDLE -> `lo`=0xAAAA5555.
  - During a running MULT, pulse `start` (op=DIVU) and `hilo_we` -> both ignored; the MULT result lands unaltered at k+33.
- Reset asserted 10 cycles into a MULTU -> `busy`=0, `hi`=`lo`=0 immediately, no `done` pulse afterward. Repeat the divide tests with `MDU_DIV_EN` undefined -> HI/LO unchanged, `done` at k+1.
